// File: rtl/uart_boot_loader.sv
// uart_boot_loader: bus-side initiator that drives the uart peripheral's
// register port to pull a length-prefixed, little-endian image from RX and
// write it word by word into memory.
// Optional build macro UART_BOOT_CHECKSUM_EN: adds a 32-bit trailer word
// that must equal (N + sum of payload words) mod 2^32.
module uart_boot_loader #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              uart_write_en,
  output logic              uart_addr,
  output logic [31:0]       uart_write_val,
  input  logic [31:0]       uart_read_val,
  input  logic [4:0]        uart_status,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_ACK, S_HDR, S_WRITE, S_DONE, S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR, PH_PAY, PH_TRL
  } phase_t;

  // Status register bit positions and the two values written to it
  localparam int          ST_RX_ERR = 4;
  localparam int          ST_RXC    = 3;
  localparam logic [31:0] ST_RX_ON  = 32'h0000_0004;
  localparam logic [31:0] ST_RX_OFF = 32'h0000_0000;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         n_q, n_d;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
`endif

  // Only the received byte and the rxc/rx_err flags matter to the loader
  logic unused_bits;
  assign unused_bits = ^{uart_read_val[31:8], uart_status[2:0]};

  // Next-state, datapath updates and peripheral register access
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    bcnt_d         = bcnt_q;
    idx_d          = idx_q;
    busy_d         = busy_q;
    done_d         = done_q;
    err_d          = err_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    word_d         = word_q;
    n_d            = n_q;
`ifdef UART_BOOT_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    uart_write_en  = 1'b0;
    uart_addr      = 1'b0;
    uart_write_val = ST_RX_OFF;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          phase_d = PH_HDR;
          bcnt_d  = 2'd0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        uart_write_en  = 1'b1;
        uart_addr      = 1'b1;
        uart_write_val = ST_RX_ON;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        // uart_addr stays 0 here so the data register is latched for ACK
        if (uart_status[ST_RX_ERR]) begin
          state_d = S_FAIL;
        end else if (uart_status[ST_RXC]) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        word_d         = {uart_read_val[7:0], word_q[31:8]};
        uart_write_en  = 1'b1;
        uart_addr      = 1'b1;
        uart_write_val = ST_RX_ON;
        bcnt_d         = bcnt_q + 2'd1;
        state_d        = S_WAIT;
        if (bcnt_q == 2'd3) begin
          case (phase_q)
            PH_HDR: state_d = S_HDR;
            PH_PAY: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR_W'(BASE_ADDR + idx_q);
              mem_wdata_d = word_d;
              state_d     = S_WRITE;
            end
            default: begin
`ifdef UART_BOOT_CHECKSUM_EN
              state_d = (word_d == sum_q) ? S_DONE : S_FAIL;
`else
              state_d = S_FAIL;
`endif
            end
          endcase
        end
      end
      S_HDR: begin
        n_d = word_q;
        if (word_q == 32'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
          sum_d   = 32'd0;
          phase_d = PH_TRL;
          state_d = S_WAIT;
`else
          state_d = S_DONE;
`endif
        end else if (word_q > MAX_WORDS) begin
          state_d = S_FAIL;
        end else begin
          idx_d   = 32'd0;
          phase_d = PH_PAY;
`ifdef UART_BOOT_CHECKSUM_EN
          sum_d   = word_q;
`endif
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
`ifdef UART_BOOT_CHECKSUM_EN
        sum_d = sum_q + mem_wdata_q;
`endif
        if (idx_q == n_q - 32'd1) begin
`ifdef UART_BOOT_CHECKSUM_EN
          phase_d = PH_TRL;
          state_d = S_WAIT;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        uart_write_en  = 1'b1;
        uart_addr      = 1'b1;
        uart_write_val = ST_RX_OFF;
        busy_d         = 1'b0;
        done_d         = 1'b1;
        state_d        = S_IDLE;
      end
      S_FAIL: begin
        uart_write_en  = 1'b1;
        uart_addr      = 1'b1;
        uart_write_val = ST_RX_OFF;
        busy_d         = 1'b0;
        err_d          = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs, cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_HDR;
      bcnt_q      <= 2'd0;
      idx_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Data registers; always loaded before they are read, so no reset
  always_ff @(posedge clk) begin
    word_q <= word_d;
    n_q    <= n_d;
`ifdef UART_BOOT_CHECKSUM_EN
    sum_q  <= sum_d;
`endif
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: a small uart peripheral model feeds byte
// streams with random inter-byte gaps; results are compared against a
// stream-level reference model of the load protocol.
module tb_uart_boot_loader;

  localparam int          ADDR_W = 16;
  localparam int unsigned BASE   = 32'h0000_FFFE;
  localparam int unsigned MAXW   = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              uart_write_en;
  logic              uart_addr;
  logic [31:0]       uart_write_val;
  logic [31:0]       uart_read_val;
  logic [4:0]        uart_status;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err;

  uart_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .uart_write_en(uart_write_en), .uart_addr(uart_addr),
    .uart_write_val(uart_write_val), .uart_read_val(uart_read_val),
    .uart_status(uart_status), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- uart peripheral model ----------------
  logic [7:0]  rx_q[$];
  int          err_at = -1;
  int          pos    = 0;
  int          gap    = 0;
  logic        p_rxen = 1'b0, p_rxc = 1'b0, p_rxerr = 1'b0;
  logic [7:0]  p_rxdata = 8'h00;
  logic [31:0] p_rdval  = 32'h0;

  assign uart_status   = {p_rxerr, p_rxc, p_rxen, 1'b1, 1'b0};
  assign uart_read_val = p_rdval;

  always @(posedge clk) begin
    logic clr;
    clr = uart_write_en && uart_addr;
    p_rdval <= uart_addr ? {27'd0, uart_status} : {24'd0, p_rxdata};
    if (clr) begin
      p_rxen  <= uart_write_val[2];
      p_rxc   <= 1'b0;
      p_rxerr <= 1'b0;
    end
    if (gap > 0) begin
      gap <= gap - 1;
    end else if (p_rxen && (!p_rxc || clr) && (err_at == pos || rx_q.size() > 0)) begin
      if (err_at == pos) begin
        p_rxerr <= 1'b1;
        err_at = -1;
      end else begin
        p_rxdata <= rx_q.pop_front();
        p_rxc    <= 1'b1;
        pos++;
      end
      gap <= $urandom_range(0, 3);
    end
  end

  // ---------------- bus monitor ----------------
  logic [47:0] wr_q[$];
  int n04 = 0, n00 = 0, viol = 0;
  logic prev_we = 1'b0, prev_uwe = 1'b0;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (uart_write_en && uart_addr && uart_write_val == 32'h4) n04++;
    if (uart_write_en && uart_addr && uart_write_val == 32'h0) n00++;
    if ((mem_we && prev_we) || (uart_write_en && prev_uwe)) viol++;
    prev_we  = mem_we;
    prev_uwe = uart_write_en;
  end

  // ---------------- reference model ----------------
  function automatic void push_word(inout logic [7:0] s[$], input logic [31:0] w);
    for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
  endfunction

  // Builds count + payload (+ correct trailer in the checksum build)
  function automatic void mk(input logic [31:0] n, input logic [31:0] w[$], output logic [7:0] s[$]);
    logic [31:0] sum;
    s = {};
    sum = n;
    push_word(s, n);
    foreach (w[i]) begin
      push_word(s, w[i]);
      sum += w[i];
    end
`ifdef UART_BOOT_CHECKSUM_EN
    push_word(s, sum);
`endif
  endfunction

  task automatic model(input logic [7:0] s[$], input int e_at, output bit d, output bit e,
                       output int acks, output logic [47:0] w[$]);
    longint avail, need, nw, n;
    logic [31:0] sum, wd;
    w = {}; d = 0; e = 0;
    avail = (e_at >= 0) ? e_at : s.size();
    if (avail < 4) begin e = 1; acks = int'(avail); return; end
    n = longint'({s[3], s[2], s[1], s[0]});
    if (n > MAXW) begin e = 1; acks = 4; return; end
    nw = (avail - 4) / 4;
    if (nw > n) nw = n;
    sum = n[31:0];
    for (int i = 0; i < int'(nw); i++) begin
      wd = {s[4+4*i+3], s[4+4*i+2], s[4+4*i+1], s[4+4*i]};
      sum += wd;
      w.push_back({ADDR_W'(BASE + i), wd});
    end
`ifdef UART_BOOT_CHECKSUM_EN
    need = 4 + 4*n + 4;
    if (avail >= need) begin
      wd = {s[need-1], s[need-2], s[need-3], s[need-4]};
      d = (wd == sum); e = !d; acks = int'(need);
    end else begin
      e = 1; acks = int'(avail);
    end
`else
    need = 4 + 4*n;
    acks = int'((avail < need) ? avail : need);
    if (nw == n) d = 1; else e = 1;
`endif
  endtask

  // ---------------- one complete load ----------------
  task automatic run_load(input string tag, input logic [7:0] s[$], input int e_at, input bit glitch);
    bit ed, ee, fin;
    int eacks;
    logic [47:0] ew[$];
    model(s, e_at, ed, ee, eacks, ew);
    wr_q.delete(); n04 = 0; n00 = 0; viol = 0;
    rx_q = s; err_at = e_at; pos = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    fin = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = (glitch && c == 5);
      if (done || err) begin fin = 1; break; end
    end
    start = 1'b0;
    chk({tag, "_finished"}, fin, 1'b1);
    chk({tag, "_done"}, done, ed);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_nwrites"}, wr_q.size(), ew.size());
    foreach (ew[i])
      if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), wr_q[i], ew[i]);
    chk({tag, "_acks04"}, n04, eacks + 1);
    chk({tag, "_rxoff00"}, n00, 1);
    chk({tag, "_strobe1"}, viol, 0);
    @(negedge clk);
    chk({tag, "_held"}, {done, err}, {ed, ee});
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int          n, ea;
    bit          fin;

    // reset state
    #2;
    chk("rst_outputs", {uart_write_en, uart_addr, uart_write_val, mem_we, mem_addr, mem_wdata, busy, done, err}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {uart_write_en, uart_addr, mem_we, busy, done, err}, '0);

    // single word 0xDEADBEEF, with a start pulse while busy
    w = '{32'hDEADBEEF};
    mk(32'd1, w, s);
    run_load("one_word", s, -1, 1'b1);

    // zero count
    w = {};
    mk(32'd0, w, s);
    run_load("zero", s, -1, 1'b0);

    // three words, address wrap across 0xFFFF
    w = '{32'h11111111, 32'h22222222, 32'h33333333};
    mk(32'd3, w, s);
    run_load("three", s, -1, 1'b0);

    // rx_err while the second payload word is in flight
    run_load("rxerr", s, 10, 1'b0);

    // count just above the limit, and the largest unsigned count
    s = {}; push_word(s, MAXW + 1);
    run_load("over_max", s, -1, 1'b0);
    s = {}; push_word(s, 32'hFFFF_FFFF);
    run_load("huge", s, -1, 1'b0);

`ifdef UART_BOOT_CHECKSUM_EN
    s = {}; push_word(s, 32'd1); push_word(s, 32'd5); push_word(s, 32'd6);
    run_load("cks_ok", s, -1, 1'b0);
    s = {}; push_word(s, 32'd1); push_word(s, 32'd5); push_word(s, 32'd7);
    run_load("cks_bad", s, -1, 1'b0);
`endif

    // randomized loads, some with an injected rx_err
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      mk(32'(n), w, s);
      ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, s.size() - 1)) : -1;
      run_load($sformatf("rand%0d", r), s, ea, 1'b0);
    end

    // asynchronous reset in the middle of the payload
    w = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F};
    mk(32'd3, w, s);
    wr_q.delete();
    rx_q = s; err_at = -1; pos = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    fin = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (wr_q.size() > 0) begin fin = 1; break; end
    end
    chk("midrst_reached_payload", fin, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {uart_write_en, uart_addr, uart_write_val, mem_we, mem_addr, mem_wdata, busy, done, err}, '0);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete(); err_at = -1;

    // recovery after reset
    w = '{32'hCAFEF00D, 32'h01234567};
    mk(32'd2, w, s);
    run_load("after_rst", s, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
